// File: rtl/risc16_cpu.sv
// risc16_cpu: multi-cycle 16-bit load/store core.
// Each instruction is FETCH then EXECUTE; HALT parks the core in an
// absorbing HALTED state until reset.
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   halted     sticky, set on the closing edge of HALT execute
//   mem_addr   PC in FETCH, regfile[rs] during LD/ST execute
//   mem_rdata  combinational read data for mem_addr
//   mem_wdata  regfile[rd] during ST execute, otherwise 0
//   mem_we     single-cycle pulse during ST execute
module risc16_cpu (
   input  logic        clk,
   input  logic        rst,
   output logic        halted,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_rdata,
   output logic [15:0] mem_wdata,
   output logic        mem_we
);

   typedef enum logic [1:0] {FETCH, EXECUTE, HALTED} state_t;

   state_t      state;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [15:0] regfile [0:15];

   logic [3:0]  op, rd, rs, rt;
   logic [15:0] rs_val, rt_val, rd_val, imm_s;
   logic [15:0] res;
   logic        wr;
   logic        is_ld, is_st, in_exec;

   assign op    = ir[15:12];
   assign rd    = ir[11:8];
   assign rs    = ir[7:4];
   assign rt    = ir[3:0];
   assign imm_s = {{8{ir[7]}}, ir[7:0]};

   // R0 is never written, but force zero on read as well so it can never leak.
   assign rs_val = (rs == 4'd0) ? 16'h0000 : regfile[rs];
   assign rt_val = (rt == 4'd0) ? 16'h0000 : regfile[rt];
   assign rd_val = (rd == 4'd0) ? 16'h0000 : regfile[rd];

   assign in_exec = (state == EXECUTE);
   assign is_ld   = (op == 4'h9);
   assign is_st   = (op == 4'hA);

   // Memory port is pure decode of state/IR/registers; mem_rdata only feeds
   // the IR and the LD writeback, never an output.
   assign mem_addr  = (in_exec && (is_ld || is_st)) ? rs_val : pc;
   assign mem_we    = in_exec && is_st;
   assign mem_wdata = (in_exec && is_st) ? rd_val : 16'h0000;

   // Writeback value for the register-writing opcodes.
   always_comb begin
      res = 16'h0000;
      wr  = 1'b1;
      case (op)
         4'h1:    res = rs_val + rt_val;
         4'h2:    res = rs_val - rt_val;
         4'h3:    res = rs_val & rt_val;
         4'h4:    res = rs_val | rt_val;
         4'h5:    res = rs_val ^ rt_val;
         4'h6:    res = rs_val << rt_val[3:0];
         4'h7:    res = rs_val >> rt_val[3:0];
         4'h8:    res = imm_s;
         4'h9:    res = mem_rdata;
         4'hD:    res = rd_val + imm_s;
         4'hE:    res = rs_val;
         default: wr  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= FETCH;
         pc     <= 16'h0000;
         ir     <= 16'h0000;
         halted <= 1'b0;
         for (int i = 0; i < 16; i++) regfile[i] <= 16'h0000;
      end else begin
         case (state)
            FETCH: begin
               ir    <= mem_rdata;
               pc    <= pc + 16'd1;
               state <= EXECUTE;
            end
            EXECUTE: begin
               state <= FETCH;
               if (wr && (rd != 4'd0)) regfile[rd] <= res;
               // pc already points past the BEQZ, so pc + imm is addr + 1 + imm.
               if (op == 4'hB && rd_val == 16'h0000) pc <= pc + imm_s;
               if (op == 4'hC) pc <= {4'h0, ir[11:0]};
               if (op == 4'hF) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_risc16_cpu.sv
// Bench for risc16_cpu: an instruction-level interpreter tracks the expected
// architectural state and port activity cycle by cycle; directed programs pin
// the interpreter with literal results, random programs exercise the rest.
module tb_risc16_cpu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halted, mem_we;
   logic [15:0] mem_addr, mem_rdata, mem_wdata;

   logic [15:0] mem [0:255];
   logic [15:0] img [0:255];

   always #5 clk = ~clk;

   risc16_cpu dut (
      .clk(clk), .rst(rst), .halted(halted), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we)
   );

   // 256-word memory aliased over the 16-bit address space.
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   // ---------------- instruction-level model ----------------
   logic [15:0] m_pc, m_ir, m_addr;
   logic [15:0] m_reg [0:15];
   logic [15:0] m_mem [0:255];
   logic        m_exec, m_halt, m_wr;
   logic [3:0]  op, rd, rs, rt;
   logic [15:0] a, b, d, imm, res;
   int          we_cnt;

   always @(negedge clk) begin
      if (!rst) begin
         chk1("rst_halted", halted, 1'b0);
         chk1("rst_mem_we", mem_we, 1'b0);
         chk("rst_mem_addr", mem_addr, 16'h0000);
         chk("rst_mem_wdata", mem_wdata, 16'h0000);
         for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), dut.regfile[i], 16'h0000);
         m_pc = 16'h0; m_ir = 16'h0; m_exec = 1'b0; m_halt = 1'b0; we_cnt = 0;
         for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
         for (int i = 0; i < 256; i++) m_mem[i] = img[i];
      end else begin
         if (mem_we) we_cnt++;
         chk1("halted", halted, m_halt);
         for (int i = 0; i < 16; i++) chk($sformatf("r%0d", i), dut.regfile[i], m_reg[i]);
         if (m_halt) begin
            chk1("halt_we", mem_we, 1'b0);
            chk("halt_wdata", mem_wdata, 16'h0000);
         end else if (!m_exec) begin
            chk("fetch_addr", mem_addr, m_pc);
            chk1("fetch_we", mem_we, 1'b0);
            chk("fetch_wdata", mem_wdata, 16'h0000);
            m_ir   = m_mem[m_pc[7:0]];
            m_addr = m_pc;
            m_pc   = m_pc + 16'd1;
            m_exec = 1'b1;
         end else begin
            op = m_ir[15:12]; rd = m_ir[11:8]; rs = m_ir[7:4]; rt = m_ir[3:0];
            a = m_reg[rs]; b = m_reg[rt]; d = m_reg[rd];
            imm = {{8{m_ir[7]}}, m_ir[7:0]};
            chk1("exec_we", mem_we, op == 4'hA);
            chk("exec_wdata", mem_wdata, (op == 4'hA) ? d : 16'h0000);
            if (op == 4'h9 || op == 4'hA) chk("exec_addr", mem_addr, a);
            m_wr = 1'b1; res = 16'h0;
            case (op)
               4'h1: res = a + b;
               4'h2: res = a - b;
               4'h3: res = a & b;
               4'h4: res = a | b;
               4'h5: res = a ^ b;
               4'h6: res = a << b[3:0];
               4'h7: res = a >> b[3:0];
               4'h8: res = imm;
               4'h9: res = m_mem[a[7:0]];
               4'hA: begin m_wr = 1'b0; m_mem[a[7:0]] = d; end
               4'hB: begin m_wr = 1'b0; if (d == 16'h0) m_pc = m_addr + 16'd1 + imm; end
               4'hC: begin m_wr = 1'b0; m_pc = {4'h0, m_ir[11:0]}; end
               4'hD: res = d + imm;
               4'hE: res = a;
               4'hF: begin m_wr = 1'b0; m_halt = 1'b1; end
               default: m_wr = 1'b0;
            endcase
            if (m_wr && rd != 4'd0) m_reg[rd] = res;
            m_exec = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 16'h0000;
   endtask

   // Enter with rst changes at posedge+2; hc = cycle count at which halted rose, -1 if never.
   task automatic run_prog(input int ncyc, output int hc);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      hc = -1;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk);
         #1;
         if (halted && hc < 0) hc = n;
      end
      #1;
   endtask

   task automatic chk_mem_all(input string nm);
      for (int i = 0; i < 256; i++) chk($sformatf("%s_mem%0d", nm, i), mem[i], m_mem[i]);
   endtask

   int hc;
   logic [15:0] w;

   initial begin
      #1 rst = 1'b0;
      @(posedge clk);
      #2;

      // ALU
      clear_img();
      img[0] = 16'h8105; img[1] = 16'h8203; img[2] = 16'h1312; img[3] = 16'h2412;
      img[4] = 16'h85FF; img[5] = 16'h1655; img[6] = 16'hF000;
      run_prog(40, hc);
      chk("alu_halt_cycle", 16'(hc), 16'd14);
      chk("alu_r3", dut.regfile[3], 16'h0008);
      chk("alu_r4", dut.regfile[4], 16'h0002);
      chk("alu_r5", dut.regfile[5], 16'hFFFF);
      chk("alu_r6", dut.regfile[6], 16'hFFFE);
      chk1("alu_halted", halted, 1'b1);

      // Memory
      clear_img();
      img[0] = 16'h8140; img[1] = 16'h827B; img[2] = 16'hA210; img[3] = 16'h9310;
      img[4] = 16'hF000;
      run_prog(30, hc);
      chk("mem_0x40", mem[8'h40], 16'h007B);
      chk("mem_r3", dut.regfile[3], 16'h007B);
      chk("mem_we_pulses", 16'(we_cnt), 16'd1);
      chk("mem_halt_cycle", 16'(hc), 16'd10);

      // Control flow, then 50+ idle cycles in HALTED
      clear_img();
      img[0] = 16'h8103; img[1] = 16'hD201; img[2] = 16'hD1FF; img[3] = 16'hB101;
      img[4] = 16'hC001; img[5] = 16'hF000;
      run_prog(80, hc);
      chk("ctl_halt_cycle", 16'(hc), 16'd26);
      chk("ctl_r1", dut.regfile[1], 16'h0000);
      chk("ctl_r2", dut.regfile[2], 16'h0003);
      chk1("ctl_sticky", halted, 1'b1);
      chk("ctl_we_pulses", 16'(we_cnt), 16'd0);
      rst = 1'b0;
      #1;
      chk1("rst_clears_halted", halted, 1'b0);

      // R0 and shifts
      clear_img();
      img[0] = 16'h8009; img[1] = 16'h8101; img[2] = 16'h8204; img[3] = 16'h6312;
      img[4] = 16'h7431; img[5] = 16'hE500; img[6] = 16'hF000;
      run_prog(30, hc);
      chk("sh_r0", dut.regfile[0], 16'h0000);
      chk("sh_r3", dut.regfile[3], 16'h0010);
      chk("sh_r4", dut.regfile[4], 16'h0008);
      chk("sh_r5", dut.regfile[5], 16'h0000);

      // Random programs, mostly non-halting; occasional HALT kept
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'hD;
            img[i] = w;
         end
         run_prog(300, hc);
         chk_mem_all($sformatf("rnd%0d", p));
      end

      // Mid-run reset on a random program
      for (int i = 0; i < 256; i++) img[i] = 16'($urandom) & 16'h7FFF;
      run_prog(37, hc);
      rst = 1'b0;
      #1;
      chk1("mid_rst_halted", halted, 1'b0);
      chk1("mid_rst_we", mem_we, 1'b0);
      chk("mid_rst_addr", mem_addr, 16'h0000);
      for (int i = 1; i < 16; i++) chk($sformatf("mid_rst_r%0d", i), dut.regfile[i], 16'h0000);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_fetch_addr", mem_addr, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
